cla_multicycle_addsub: RTL and testbench

// Parametrised multi-cycle add/subtract unit built from 4-bit carry-look-ahead slices.

---
 rtl/cla_multicycle_addsub.sv | 176 +++++++++++++++++
 tb/tb_cla_multicycle_addsub.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/cla_multicycle_addsub.sv
// ---------------------------------------------------------------------------
// cla_multicycle_addsub
//
// Multi-cycle add/subtract unit. A WIDTH-bit operation is computed CHUNK bits
// per clock through CHUNK/4 cascaded 4-bit carry-look-ahead slices, with the
// inter-chunk carry held in a register. A wide datapath can therefore share
// one small adder.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   op_start   operands valid this cycle (accepted only while op_ready=1)
//   op_ready   unit idle, can accept op_start
//   op_a/op_b  operands
//   op_sub     0: A+B+ci   1: A-B-ci (ci is borrow-in)
//   op_ci      carry-in / borrow-in
//   res_valid  result outputs valid, held until res_ready
//   res_ready  consumer accepts the result
//   res_sum    result (modulo 2^WIDTH)
//   res_co     carry-out (add) / borrow-out (sub)
//   res_ovf    two's-complement signed overflow
//   res_zero   res_sum == 0
// ---------------------------------------------------------------------------
module cla_multicycle_addsub #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             op_start,
    output logic             op_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_sub,
    input  logic             op_ci,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_co,
    output logic             res_ovf,
    output logic             res_zero
);

    localparam int NCYC   = WIDTH / CHUNK;
    localparam int NSLICE = CHUNK / 4;
    localparam int KW     = (NCYC > 1) ? $clog2(NCYC) : 1;

    generate
        if ((WIDTH % CHUNK) != 0 || (CHUNK % 4) != 0) begin : g_param_err
            $error("cla_multicycle_addsub: WIDTH must be a multiple of CHUNK and CHUNK a multiple of 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  a_reg, b_reg;       // operands, shifted down one chunk per cycle
    logic              carry_reg;
    logic              sub_reg;
    logic              a_msb_reg, b_msb_reg; // sign bits of A and B' for overflow
    logic [KW-1:0]     k_reg;
    logic [WIDTH-1:0]  res_sum_reg;
    logic              co_reg, ovf_reg, zero_reg;

    logic [CHUNK-1:0]  chunk_sum;
    logic [NSLICE:0]   slice_c;
    logic [WIDTH-1:0]  sum_next;
    logic              calc_last;

    assign calc_last = (k_reg == KW'(NCYC - 1));

    // Chunk adder: the current chunk is always the low CHUNK bits of the
    // shifting operand registers.
    assign slice_c[0] = carry_reg;
    generate
        for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
            logic [3:0] g, p;
            logic [4:0] c;
            assign g = a_reg[gi*4 +: 4] & b_reg[gi*4 +: 4];
            assign p = a_reg[gi*4 +: 4] ^ b_reg[gi*4 +: 4];
            assign c[0] = slice_c[gi];
            assign c[1] = g[0] | (p[0] & c[0]);
            assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
            assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                        | (p[2] & p[1] & p[0] & c[0]);
            assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                        | (p[3] & p[2] & p[1] & g[0])
                        | (p[3] & p[2] & p[1] & p[0] & c[0]);
            assign chunk_sum[gi*4 +: 4] = p ^ c[3:0];
            assign slice_c[gi+1] = c[4];
        end

        // Result chunks enter at the top and shift down, so after NCYC
        // cycles chunk 0 sits at bit 0.
        if (NCYC == 1) begin : g_sum_one
            assign sum_next = chunk_sum;
        end else begin : g_sum_multi
            assign sum_next = {chunk_sum, res_sum_reg[WIDTH-1:CHUNK]};
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (op_start)  state_next = CALC;
            CALC:    if (calc_last) state_next = DONE;
            DONE:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        op_ready  = (state_reg == IDLE);
        res_valid = (state_reg == DONE);
    end

    // Datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_reg       <= '0;
            b_reg       <= '0;
            carry_reg   <= 1'b0;
            sub_reg     <= 1'b0;
            a_msb_reg   <= 1'b0;
            b_msb_reg   <= 1'b0;
            k_reg       <= '0;
            res_sum_reg <= '0;
            co_reg      <= 1'b0;
            ovf_reg     <= 1'b0;
            zero_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (op_start) begin
                        a_reg     <= op_a;
                        b_reg     <= op_sub ? ~op_b : op_b;
                        carry_reg <= op_sub ? ~op_ci : op_ci;
                        sub_reg   <= op_sub;
                        a_msb_reg <= op_a[WIDTH-1];
                        b_msb_reg <= op_b[WIDTH-1] ^ op_sub;
                        k_reg     <= '0;
                    end
                end
                CALC: begin
                    a_reg       <= a_reg >> CHUNK;
                    b_reg       <= b_reg >> CHUNK;
                    carry_reg   <= slice_c[NSLICE];
                    res_sum_reg <= sum_next;
                    k_reg       <= k_reg + KW'(1);
                    if (calc_last) begin
                        // Subtract computes A + ~B + ~ci, so borrow = ~carry.
                        co_reg   <= slice_c[NSLICE] ^ sub_reg;
                        ovf_reg  <= (a_msb_reg == b_msb_reg)
                                 && (chunk_sum[CHUNK-1] != a_msb_reg);
                        zero_reg <= ~|sum_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_sum  = res_sum_reg;
    assign res_co   = co_reg;
    assign res_ovf  = ovf_reg;
    assign res_zero = zero_reg;

endmodule

// File: tb/tb_cla_multicycle_addsub.sv
// Directed testbench for cla_multicycle_addsub (WIDTH=64, CHUNK=16).
module tb_cla_multicycle_addsub;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        op_start;
    logic        op_ready;
    logic [63:0] op_a, op_b;
    logic        op_sub, op_ci;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_sum;
    logic        res_co, res_ovf, res_zero;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;

    always #5 clk = ~clk;

    cla_multicycle_addsub #(.WIDTH(64), .CHUNK(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .op_start  (op_start),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sub    (op_sub),
        .op_ci     (op_ci),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_co    (res_co),
        .res_ovf   (res_ovf),
        .res_zero  (res_zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %h", tag, got);
        end
    endtask

    // Issue one operation and wait (bounded) for res_valid; lat counts
    // cycles from the accepting edge to the first valid sample.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                          input logic sub, input logic ci, output int l);
        int guard = 0;
        @(negedge clk);
        while (!op_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        op_a = a; op_b = b; op_sub = sub; op_ci = ci; op_start = 1'b1;
        @(posedge clk);
        #1 op_start = 1'b0;
        l = 0;
        while (!res_valid && l < 20) begin
            @(posedge clk);
            #1 l++;
        end
    endtask

    task automatic release_result(input string tag);
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        check({tag, "_valid_drop"}, {63'd0, res_valid}, 64'd0);
        check({tag, "_ready_back"}, {63'd0, op_ready}, 64'd1);
    endtask

    task automatic expect_res(input string tag, input logic [63:0] s,
                              input logic co, input logic ovf, input logic z);
        check({tag, "_lat"},  64'(lat), 64'd4);
        check({tag, "_sum"},  res_sum, s);
        check({tag, "_co"},   {63'd0, res_co}, {63'd0, co});
        check({tag, "_ovf"},  {63'd0, res_ovf}, {63'd0, ovf});
        check({tag, "_zero"}, {63'd0, res_zero}, {63'd0, z});
    endtask

    initial begin
        reset_n = 1'b0; op_start = 1'b0; op_a = '0; op_b = '0;
        op_sub = 1'b0; op_ci = 1'b0; res_ready = 1'b0;
        #12;
        check("rst_ready", {63'd0, op_ready}, 64'd1);
        check("rst_valid", {63'd0, res_valid}, 64'd0);
        check("rst_sum",   res_sum, 64'd0);
        check("rst_flags", {61'd0, res_co, res_ovf, res_zero}, 64'd0);
        @(negedge clk) reset_n = 1'b1;

        // 1. all-ones + 1 wraps to zero
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, lat);
        check("t1_ready_busy", {63'd0, op_ready}, 64'd0);
        expect_res("t1", 64'd0, 1'b1, 1'b0, 1'b1);
        release_result("t1");

        // 2. carry crosses a chunk boundary
        run_op(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, lat);
        expect_res("t2", 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0);
        release_result("t2");

        // 3. subtract with borrow out, then with borrow in
        run_op(64'd5, 64'd7, 1'b1, 1'b0, lat);
        expect_res("t3a", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0);
        release_result("t3a");
        run_op(64'd7, 64'd5, 1'b1, 1'b1, lat);
        expect_res("t3b", 64'd1, 1'b0, 1'b0, 1'b0);
        release_result("t3b");

        // 4. signed overflow on add and sub
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, lat);
        expect_res("t4a", 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
        release_result("t4a");
        run_op(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, lat);
        expect_res("t4b", 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
        release_result("t4b");

        // 5. backpressure: result held, op_start ignored and not queued
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd4, 1'b0, 1'b0, lat);
        expect_res("t5", 64'd3, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            op_a = 64'(i + 100); op_b = 64'(i); op_start = 1'b1;
            @(posedge clk);
            #1 op_start = 1'b0;
            check($sformatf("t5_hold%0d", i),
                  {res_sum[60:0], res_valid, op_ready, res_co}, {61'd3, 1'b1, 1'b0, 1'b1});
        end
        release_result("t5");
        repeat (2) @(posedge clk);
        #1 check("t5_not_queued", {62'd0, res_valid, op_ready}, 64'd1);

        // 6. asynchronous reset in the middle of CALC
        @(negedge clk);
        op_a = 64'h0001_0001_0001_0001; op_b = 64'h0001_0001_0001_0001;
        op_sub = 1'b0; op_ci = 1'b0; op_start = 1'b1;
        @(posedge clk);
        #1 op_start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("t6_rst_ready", {63'd0, op_ready}, 64'd1);
        check("t6_rst_valid", {63'd0, res_valid}, 64'd0);
        check("t6_rst_sum",   res_sum, 64'd0);
        check("t6_rst_flags", {61'd0, res_co, res_ovf, res_zero}, 64'd0);
        @(negedge clk) reset_n = 1'b1;
        run_op(64'd3, 64'd4, 1'b0, 1'b0, lat);
        expect_res("t6", 64'd7, 1'b0, 1'b0, 1'b0);
        release_result("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
